tlul_host_arbiter: RTL and testbench



---
 rtl/config_pkg.sv | 8 +
 rtl/tlul_pkg.sv | 40 ++++
 rtl/tlul_arb_idx_fifo.sv | 61 ++++++
 rtl/tlul_host_arbiter.sv | 105 ++++++++++
 tb/tb_tlul_host_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Fabric-wide defaults for the host arbiter.
// Host count and response-routing FIFO depth.
package config_pkg;

  localparam int NumHosts       = 2;
  localparam int MaxOutstanding = 4;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel bundles and opcodes shared by
// the hosts, the arbiter and the device port.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idx_fifo.sv
// Host-index FIFO steering D responses back
// to the host whose request was granted.
module tlul_arb_idx_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage and pointer/occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      unique case (1'b1)
        (do_push & ~do_pop): cnt <= cnt + 1'b1;
        (do_pop & ~do_push): cnt <= cnt - 1'b1;
        default:             cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Round-robin TL-UL host arbiter with grant
// lock and in-order D-channel steering.
module tlul_host_arbiter
  import tlul_pkg::*;
#(
  parameter int NumHosts       = config_pkg::NumHosts,
  parameter int MaxOutstanding = config_pkg::MaxOutstanding,
  localparam int IdxW          = $clog2(NumHosts)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  tl_h2d_t host_req_i [NumHosts],
  output tl_d2h_t host_rsp_o [NumHosts],
  output tl_h2d_t dev_req_o,
  input  tl_d2h_t dev_rsp_i,
  output logic    err_unexp_d_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;
  logic            err_q;
  logic [IdxW-1:0] rr_idx;
  logic            rr_found;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] head;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;

  // Search from the pointer upward for the first requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int i = 0; i < NumHosts; i++) begin
      if (!rr_found &&
          host_req_i[(int'(ptr_q) + i) % NumHosts].a_valid) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'((int'(ptr_q) + i) % NumHosts);
      end
    end
  end

  assign win = lock_q ? lock_idx_q : rr_idx;

  // Forward the winner; drain stray responses when idle.
  always_comb begin
    dev_req_o         = host_req_i[win];
    dev_req_o.a_valid = rst_n & host_req_i[win].a_valid & ~full;
    dev_req_o.d_ready = rst_n &
                        (empty | host_req_i[head].d_ready);
  end

  // Per-host a_ready grant and D-channel steering.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      host_rsp_o[h]         = dev_rsp_i;
      host_rsp_o[h].d_valid = rst_n & dev_rsp_i.d_valid &
                              ~empty & (head == IdxW'(h));
      host_rsp_o[h].a_ready = rst_n & dev_rsp_i.a_ready &
                              ~full & (win == IdxW'(h));
    end
  end

  assign accept = dev_req_o.a_valid & dev_rsp_i.a_ready;
  assign pop    = dev_rsp_i.d_valid & dev_req_o.d_ready & ~empty;

  assign err_unexp_d_o = err_q;

  // Pointer advance, stall lock and stray-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= dev_rsp_i.d_valid & empty;
      if (accept) begin
        lock_q <= 1'b0;
        ptr_q  <= (win == IdxW'(NumHosts - 1)) ?
                  '0 : win + 1'b1;
      end else if (dev_req_o.a_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win;
      end
    end
  end

  tlul_arb_idx_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_idx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wdata (win),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Randomized bench for tlul_host_arbiter with a
// transaction-level reference model and device.
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  localparam int N  = 3;
  localparam int MO = 2;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t hreq [N];
  tl_d2h_t hrsp [N];
  tl_h2d_t dreq;
  tl_d2h_t drsp;
  logic    err;

  always #5 clk = ~clk;

  tlul_host_arbiter #(
    .NumHosts       (N),
    .MaxOutstanding (MO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_req_i    (hreq),
    .host_rsp_o    (hrsp),
    .dev_req_o     (dreq),
    .dev_rsp_i     (drsp),
    .err_unexp_d_o (err)
  );

  typedef struct {
    logic [7:0]  src;
    tl_a_op_e    op;
    logic [31:0] data;
  } rsp_t;

  int   passed = 0;
  int   total  = 0;
  int   ptr;
  bit   locked;
  int   lk;
  int   mq [$];
  rsp_t dq [$];
  bit   dv_hold;
  bit   err_exp;
  bit   pend [N];
  int   seq  [N];
  int   rseq [N];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    ptr = 0; locked = 0; lk = 0;
    mq.delete(); dq.delete();
    dv_hold = 0; err_exp = 0;
    for (int h = 0; h < N; h++) begin
      pend[h] = 0; seq[h] = 0; rseq[h] = 0;
      hreq[h] = '0;
    end
    drsp = '0;
  endtask

  task automatic drive(int mode);
    for (int h = 0; h < N; h++) begin
      if (!pend[h]) begin
        hreq[h].a_valid = 1'b0;
        if (mode == 1 || $urandom_range(0, 2) == 0) begin
          pend[h] = 1;
          hreq[h].a_valid   = 1'b1;
          case ($urandom_range(0, 2))
            0: hreq[h].a_opcode = Get;
            1: hreq[h].a_opcode = PutFullData;
            default: hreq[h].a_opcode = PutPartialData;
          endcase
          hreq[h].a_source  = 8'((h << 4) | (seq[h] & 15));
          hreq[h].a_address = $urandom;
          hreq[h].a_data    = $urandom;
          hreq[h].a_mask    = 4'hf;
          hreq[h].a_size    = 2'd2;
          seq[h]++;
        end
      end
      hreq[h].d_ready = (mode == 1) ? 1'b1 :
                        ($urandom_range(0, 3) != 0);
    end
    case (mode)
      1: drsp.a_ready = 1'b1;
      2: drsp.a_ready = ($urandom_range(0, 3) == 0);
      default: drsp.a_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (!dv_hold) begin
      drsp.d_valid = 1'b0;
      if (dq.size() > 0 &&
          (mode == 1 ||
           (mode == 3 ? $urandom_range(0, 5) == 0
                      : $urandom_range(0, 1) == 0))) begin
        drsp.d_valid  = 1'b1;
        drsp.d_source = dq[0].src;
        drsp.d_data   = dq[0].data;
        drsp.d_opcode = (dq[0].op == Get) ?
                        AccessAckData : AccessAck;
        dv_hold = 1;
      end else if (mode == 0 && dq.size() == 0 &&
                   $urandom_range(0, 7) == 0) begin
        drsp.d_valid  = 1'b1;
        drsp.d_source = 8'hee;
      end
    end
  endtask

  task automatic check_update();
    int  w;
    bit  full;
    bit  exp_av;
    bit  acc;
    bit  popd;
    int  hd;
    bit  exp_dr;
    rsp_t r;
    full = (mq.size() == MO);
    w = ptr;
    if (locked) w = lk;
    else begin
      for (int i = N - 1; i >= 0; i--)
        if (hreq[(ptr + i) % N].a_valid) w = (ptr + i) % N;
    end
    exp_av = hreq[w].a_valid && !full;
    chk("dev_a_valid", dreq.a_valid, exp_av);
    if (exp_av) begin
      chk("dev_a_source", dreq.a_source, hreq[w].a_source);
      chk("dev_a_addr", dreq.a_address, hreq[w].a_address);
    end
    for (int h = 0; h < N; h++)
      chk($sformatf("a_ready%0d", h), hrsp[h].a_ready,
          (h == w) && drsp.a_ready && !full);
    hd = (mq.size() > 0) ? mq[0] : -1;
    exp_dr = (hd < 0) ? 1'b1 : hreq[hd].d_ready;
    chk("dev_d_ready", dreq.d_ready, exp_dr);
    for (int h = 0; h < N; h++)
      chk($sformatf("d_valid%0d", h), hrsp[h].d_valid,
          (h == hd) && drsp.d_valid);
    popd = (hd >= 0) && drsp.d_valid && exp_dr;
    if (popd) begin
      chk("d_route", hrsp[hd].d_source[7:4], hd);
      chk("d_order", hrsp[hd].d_source[3:0],
          rseq[hd] & 15);
      rseq[hd]++;
    end
    chk("err_unexp", err, err_exp);
    err_exp = drsp.d_valid && (mq.size() == 0);
    acc = exp_av && drsp.a_ready;
    if (popd) begin
      void'(mq.pop_front());
      void'(dq.pop_front());
      dv_hold = 0;
    end
    if (acc) begin
      mq.push_back(w);
      r.src = hreq[w].a_source;
      r.op = hreq[w].a_opcode;
      r.data = $urandom;
      dq.push_back(r);
      ptr = (w + 1) % N;
      locked = 0;
      pend[w] = 0;
    end else if (exp_av) begin
      locked = 1;
      lk = w;
    end
  endtask

  task automatic run(int mode, int n);
    repeat (n) begin
      drive(mode);
      @(negedge clk);
      check_update();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    for (int h = 0; h < N; h++) begin
      chk({tag, "_a_ready"}, hrsp[h].a_ready, 1'b0);
      chk({tag, "_d_valid"}, hrsp[h].d_valid, 1'b0);
    end
    chk({tag, "_dev_a_valid"}, dreq.a_valid, 1'b0);
    chk({tag, "_dev_d_ready"}, dreq.d_ready, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    model_clear();
    for (int h = 0; h < N; h++) hreq[h].a_valid = 1'b1;
    drsp.a_ready = 1'b1;
    drsp.d_valid = 1'b1;
    #2;
    check_reset_outputs("rst");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(0, 300);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1);
    @(negedge clk);
    chk("first_after_rst", dreq.a_source[7:4], 0);
    check_update();
    @(posedge clk);
    #1;
    run(1, 200);
    run(2, 300);
    run(3, 300);
    run(0, 200);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
